evt_pulse_shaper: RTL and testbench
===================================

# evt_pulse_shaper

Source-side event shaper that turns single-cycle event requests into clean, registered pulses on a single level output. Each pulse is held for a fixed high time and followed by a fixed low gap. The output drives the asynchronous pulse input of a downstream CDC-synchronized FSM, so every event survives synchronization plus that FSM's two-cycle stability check. Events that arrive while a pulse is in flight are queued in a saturating pending counter. A sent-pulse counter lets benches compare against the downstream event count.

## Interface
- `HIGH_CYCLES`, default 4: `pulse_o` high time in `clk_i` cycles. Must be ≥1.
- `LOW_CYCLES`, default 4: mandatory low gap after each pulse. Must be ≥1.
- `MAX_PENDING`, default 15: pending-queue capacity. Must be ≥1.
- `CNT_W`, default `$clog2(MAX_PENDING+1)`: width of `pending_o`.
- `clk_i`, in, 1: the block's single clock.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `evt_valid_i`, in, 1: event request.
- `evt_ready_o`, out, 1: combinational; equals `pending_o != MAX_PENDING`.
- `clr_i`, in, 1: synchronous clear of the queue and the overflow flag.
- `pulse_o`, out, 1: registered, glitch-free output pulse.
- `pending_o`, out, `CNT_W`: queued events not yet started.
- `overflow_o`, out, 1: sticky flag; an event was offered while not ready.
- `sent_cnt_o`, out, 16: completed-pulse counter; wraps.

## Operation
- Accept: an event is accepted when `evt_valid_i && evt_ready_o` is sampled at a rising edge.
- Overflow: `evt_valid_i && !evt_ready_o` sets `overflow_o` at that edge and drops the event.
- Pending counter, at each edge:
  - +1 on accept.
  - −1 on pulse start.
  - Unchanged when both happen in the same edge.
  - Never wraps.
- FSM states are IDLE, HIGH and LOW.
  - IDLE → HIGH when `pending_o != 0`. This transition is a pulse start.
  - HIGH → LOW after exactly `HIGH_CYCLES` cycles in HIGH. `sent_cnt_o` increments on this transition.
  - LOW → HIGH after `LOW_CYCLES` cycles if `pending_o != 0`. This transition is a pulse start.
  - LOW → IDLE after `LOW_CYCLES` cycles otherwise.
- The start decision uses the registered `pending_o`. An event accepted at the same edge is not seen until the next edge.
- `pulse_o` is a flop loaded from `next_state == HIGH`. It never toggles inside a pulse.
- `clr_i`:
  - Forces `pending_o` to 0 and `overflow_o` to 0 at the next edge.
  - Overrides any accept or overflow in the same cycle; that event is dropped and no flag is set.
  - Does not abort a pulse in HIGH or LOW, so the downstream integrity holds.
  - Does not clear `sent_cnt_o`.
- `sent_cnt_o` wraps 16'hFFFF → 16'h0000.
- Sizing rule for integrators: choose `HIGH_CYCLES` and `LOW_CYCLES` so that each phase spans at least 4 destination clock periods plus one source period (2 for the sync, 2 for the stability check).

## Timing
- Reset values:
  - FSM state IDLE.
  - `pulse_o` = 0.
  - `pending_o` = 0.
  - `overflow_o` = 0.
  - `sent_cnt_o` = 0.
  - `evt_ready_o` = 1.
  - Internal phase counter = 0.
- Latency from accept:
  - Accept at edge k in IDLE makes `pending_o` = 1 after edge k.
  - `pulse_o` rises at edge k+1.
  - `pulse_o` falls at edge k+1+`HIGH_CYCLES`.
  - The state returns to IDLE at edge k+1+`HIGH_CYCLES`+`LOW_CYCLES`.
- Back-to-back pulses have period `HIGH_CYCLES`+`LOW_CYCLES` with no IDLE cycle between them.
- Reset asserted mid-pulse: `pulse_o` drops immediately (asynchronously) and all state returns to reset values.
- Phase counter width is `$clog2(max(HIGH_CYCLES, LOW_CYCLES)+1)`. It reloads to 0 on every state change.

## Structure
- Package `evt_pulse_shaper_pkg` holds:
  - `shaper_state_t` enum {IDLE, HIGH, LOW}, 2-bit.
  - `SENT_CNT_W` = 16.
- Sub-module `sat_updown_ctr` is a parameterized saturating up/down counter with synchronous clear. It implements `pending_o` and the `evt_ready_o` derivation.
- The top level holds the FSM, the phase counter, the `pulse_o` flop, the overflow flag and `sent_cnt_o`.

## Test plan
All scenarios use `HIGH_CYCLES`=4, `LOW_CYCLES`=3, `MAX_PENDING`=3.

- Reset release with no events:
  - Stimulus: release `rst_ni` and hold `evt_valid_i` low for 20 cycles.
  - Required response: `pulse_o`=0, `pending_o`=0, `overflow_o`=0, `sent_cnt_o`=0 throughout.
- Single event:
  - Stimulus: one valid event at edge 10.
  - Required response: `pulse_o` high from edge 11 to edge 15; IDLE at edge 18; `sent_cnt_o`=1; `pending_o` reads 1 only between edges 10 and 11.
- Burst with overflow:
  - Stimulus: `evt_valid_i` high for 5 consecutive cycles starting in IDLE.
  - Required response:
    - `pending_o` peaks at 3.
    - `evt_ready_o` drops while `pending_o`=3.
    - `overflow_o` is set.
    - Exactly 4 back-to-back pulses of 7-cycle period follow, with no IDLE between them.
    - `sent_cnt_o`=4 at the end.
- Clear during a pulse:
  - Stimulus: `pending_o`=2 with the FSM in HIGH; assert `clr_i` together with `evt_valid_i`.
  - Required response:
    - The current pulse completes its full 4-cycle high time.
    - `pending_o`=0 and `overflow_o`=0 after the clear edge.
    - The event offered with `clr_i` is dropped.
    - No further pulses occur.
- Async reset mid-pulse:
  - Stimulus: assert `rst_ni` low in the 2nd HIGH cycle, between clock edges.
  - Required response: `pulse_o` goes to 0 at once, before the next edge; all outputs return to reset values.
- Counter wrap plus end-to-end check:
  - Stimulus: preload or force `sent_cnt_o` to 16'hFFFF, then send one event.
  - Required response: `sent_cnt_o` becomes 16'h0000.
  - End-to-end: drive the downstream FSM's async pulse input from `pulse_o` with sizing per the rule above; after 1000 random events its count matches `sent_cnt_o`.

Source files
------------

// File: rtl/evt_pulse_shaper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : evt_pulse_shaper_pkg
//  Brief    : Shared types and constants for the event pulse shaper.
//  Revision : 1.0 - initial release
// ============================================================================
package evt_pulse_shaper_pkg;

   // Shaper FSM encoding; explicit values keep the encoding stable for
   // anything that inspects the state register directly.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } shaper_state_t;

   // Width of the completed-pulse counter.
   localparam int SENT_CNT_W = 16;

   // Larger of two integers, used for elaboration-time sizing.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : evt_pulse_shaper_pkg
`default_nettype wire

// File: rtl/evt_pulse_shaper_if.sv
`default_nettype none
// ============================================================================
//  Module   : evt_pulse_shaper_if
//  Brief    : Event request / pulse output bundle for evt_pulse_shaper.
//             The master side offers events and clears; the slave side is
//             the shaper itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface evt_pulse_shaper_if #(
   parameter int CNT_W = 4
) ();
   import evt_pulse_shaper_pkg::*;

   logic                  evt_valid_i;
   logic                  evt_ready_o;
   logic                  clr_i;
   logic                  pulse_o;
   logic [CNT_W-1:0]      pending_o;
   logic                  overflow_o;
   logic [SENT_CNT_W-1:0] sent_cnt_o;

   modport master (
      output evt_valid_i,
      output clr_i,
      input  evt_ready_o,
      input  pulse_o,
      input  pending_o,
      input  overflow_o,
      input  sent_cnt_o
   );

   modport slave (
      input  evt_valid_i,
      input  clr_i,
      output evt_ready_o,
      output pulse_o,
      output pending_o,
      output overflow_o,
      output sent_cnt_o
   );

endinterface : evt_pulse_shaper_if
`default_nettype wire

// File: rtl/evt_pulse_shaper_sat_updown_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : sat_updown_ctr
//  Brief    : Saturating up/down counter with synchronous clear. Holds the
//             number of queued events and flags when the queue has room.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_updown_ctr #(
   parameter int MAX_VAL = 15,
   parameter int W       = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         clr,
   input  wire logic         inc,
   input  wire logic         dec,
   output logic [W-1:0]      count,
   output logic              not_full
);

   localparam logic [W-1:0] FULL = W'(MAX_VAL);

   // Simultaneous inc and dec cancel; both directions stop at the rails so
   // the count can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !dec && (count != FULL)) begin
         count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign not_full = (count != FULL);

endmodule : sat_updown_ctr
`default_nettype wire

// File: rtl/evt_pulse_shaper.sv
`default_nettype none
// ============================================================================
//  Module   : evt_pulse_shaper
//  Brief    : Turns single-cycle event requests into fixed-width registered
//             pulses separated by a fixed low gap, so each event survives a
//             downstream synchronizer plus stability filter. Events arriving
//             during a pulse are queued in a saturating pending counter.
//  Revision : 1.0 - initial release
// ============================================================================
module evt_pulse_shaper
   import evt_pulse_shaper_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 4,
   parameter int MAX_PENDING = 15,
   parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  wire logic         clk_i,
   input  wire logic         rst_ni,
   evt_pulse_shaper_if.slave bus
);

   // Phase counter only needs to reach the longer of the two phase lengths.
   localparam int PH_W = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_HIGH = 2'(HIGH);
   localparam logic [1:0] ST_LOW  = 2'(LOW);

   localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
   localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYCLES - 1);

   logic [1:0]            state;
   logic [1:0]            next_state;
   logic [PH_W-1:0]       phase;
   logic                  high_done;
   logic                  low_done;
   logic                  start;
   logic                  accept;
   logic                  sent_inc;
   logic                  ready;
   logic                  pulse;
   logic                  overflow;
   logic [CNT_W-1:0]      pending;
   logic [SENT_CNT_W-1:0] sent_cnt;

   // A clear in the same cycle drops the offered event.
   assign accept    = bus.evt_valid_i && ready && !bus.clr_i;
   assign high_done = (phase == HIGH_LAST);
   assign low_done  = (phase == LOW_LAST);

   // Every entry into HIGH consumes one queued event.
   assign start     = (next_state == ST_HIGH) && (state != ST_HIGH);
   assign sent_inc  = (state == ST_HIGH) && high_done;

   // Queue of events not yet started.
   sat_updown_ctr #(
      .MAX_VAL (MAX_PENDING),
      .W       (CNT_W)
   ) u_pending (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clr      (bus.clr_i),
      .inc      (accept),
      .dec      (start),
      .count    (pending),
      .not_full (ready)
   );

   // Next-state decode; start decisions look only at the registered count.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (pending != '0) next_state = ST_HIGH;
         end
         ST_HIGH: begin
            if (high_done) next_state = ST_LOW;
         end
         ST_LOW: begin
            if (low_done) next_state = (pending != '0) ? ST_HIGH : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State, phase counter and output pulse register; the pulse is a pure
   // flop of the next state so it cannot glitch or toggle within a phase.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_IDLE;
         phase <= '0;
         pulse <= 1'b0;
      end else begin
         state <= next_state;
         pulse <= (next_state == ST_HIGH);
         if ((next_state != state) || (state == ST_IDLE)) begin
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   // Sticky overflow flag; clear wins over a same-cycle overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow <= 1'b0;
      end else if (bus.clr_i) begin
         overflow <= 1'b0;
      end else if (bus.evt_valid_i && !ready) begin
         overflow <= 1'b1;
      end
   end

   // Completed-pulse counter; wraps naturally and ignores clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sent_cnt <= '0;
      end else if (sent_inc) begin
         sent_cnt <= sent_cnt + 1'b1;
      end
   end

   assign bus.evt_ready_o = ready;
   assign bus.pulse_o     = pulse;
   assign bus.pending_o   = pending;
   assign bus.overflow_o  = overflow;
   assign bus.sent_cnt_o  = sent_cnt;

endmodule : evt_pulse_shaper
`default_nettype wire

// File: tb/tb_evt_pulse_shaper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_evt_pulse_shaper
//  Brief    : Self-checking bench for evt_pulse_shaper (H=4, L=3, MAX=3).
//             Expected pulse start edges are queued by the stimulus and
//             consumed by a pulse monitor; a downstream sync+filter model
//             counts pulses for the end-to-end comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_evt_pulse_shaper;

   localparam int H  = 4;
   localparam int L  = 3;
   localparam int MP = 3;
   localparam int CW = 2;

   logic clk   = 1'b0;
   logic dclk  = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk  = ~clk;
   always #2 dclk = ~dclk;

   evt_pulse_shaper_if #(.CNT_W(CW)) bus ();

   evt_pulse_shaper #(
      .HIGH_CYCLES (H),
      .LOW_CYCLES  (L),
      .MAX_PENDING (MP),
      .CNT_W       (CW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Edge counter: after rising edge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard / pulse monitor ----------------
   int exp_rise[$];
   bit sb_en = 1'b1;

   initial begin : monitor
      int rise_at;
      bit in_pulse;
      bit prev;
      rise_at  = 0;
      in_pulse = 1'b0;
      prev     = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_pulse = 1'b0;
            prev     = 1'b0;
         end else begin
            if (sb_en) begin
               if (bus.pulse_o && !prev) begin
                  rise_at  = cyc;
                  in_pulse = 1'b1;
                  if (exp_rise.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL pulse_unexpected: actual=rise@%0d required=no pulse", cyc);
                  end else begin
                     check("pulse_rise_edge", cyc, exp_rise.pop_front());
                  end
               end else if (!bus.pulse_o && prev && in_pulse) begin
                  check("pulse_high_width", cyc - rise_at, H);
                  in_pulse = 1'b0;
               end
            end
            prev = bus.pulse_o;
         end
      end
   end

   // ---------------- downstream sync + stability filter model ----------------
   int ds_cnt = 0;

   initial begin : downstream
      logic [1:0] sync;
      logic       lvl;
      int         same;
      sync = 2'b00;
      lvl  = 1'b0;
      same = 0;
      forever begin
         @(posedge dclk);
         sync = {sync[0], bus.pulse_o};
         if (sync[1] != lvl) begin
            same++;
            if (same >= 2) begin
               lvl  = sync[1];
               same = 0;
               if (lvl) ds_cnt++;
            end
         end else begin
            same = 0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pulse"},    int'(bus.pulse_o),    0);
      check({tag, "_pending"},  int'(bus.pending_o),  0);
      check({tag, "_overflow"}, int'(bus.overflow_o), 0);
      check({tag, "_sent"},     int'(bus.sent_cnt_o), 0);
      check({tag, "_ready"},    int'(bus.evt_ready_o), 1);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int k;
      int e0;
      int idle_cnt;
      int acc;
      int ds_base;
      int sent_base;
      int exp_p[5];
      exp_p = '{1, 1, 2, 3, 3};

      bus.evt_valid_i = 1'b0;
      bus.clr_i       = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      check("rst_state", int'(dut.state), 0);

      // Reset release, idle for 20 cycles.
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_outputs", int'({bus.pulse_o, bus.pending_o, bus.overflow_o, bus.sent_cnt_o}), 0);
      end

      // Single event accepted at edge k.
      bus.evt_valid_i = 1'b1;
      k = cyc + 1;
      exp_rise.push_back(k + 1);
      tick();
      bus.evt_valid_i = 1'b0;
      check("single_pending_k", int'(bus.pending_o), 1);
      check("single_pulse_k", int'(bus.pulse_o), 0);
      tick();
      check("single_pulse_k1", int'(bus.pulse_o), 1);
      check("single_pending_k1", int'(bus.pending_o), 0);
      repeat (3) tick();
      check("single_pulse_k4", int'(bus.pulse_o), 1);
      tick();
      check("single_pulse_k5", int'(bus.pulse_o), 0);
      check("single_sent", int'(bus.sent_cnt_o), 1);
      repeat (2) tick();
      check("single_not_idle_k7", int'(dut.state == 2'd0), 0);
      tick();
      check("single_idle_k8", int'(dut.state), 0);

      // Burst of 5 valid cycles: 4 accepted, 1 overflow.
      bus.evt_valid_i = 1'b1;
      e0 = cyc + 1;
      for (int i = 0; i < 4; i++) exp_rise.push_back(e0 + 1 + 7 * i);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("burst_pending", int'(bus.pending_o), exp_p[i]);
         check("burst_ready", int'(bus.evt_ready_o), (exp_p[i] != MP) ? 1 : 0);
      end
      bus.evt_valid_i = 1'b0;
      check("burst_overflow", int'(bus.overflow_o), 1);
      idle_cnt = 0;
      while (cyc < e0 + 28) begin
         tick();
         if (dut.state == 2'd0) idle_cnt++;
      end
      check("burst_no_idle_gap", idle_cnt, 0);
      tick();
      check("burst_idle_end", int'(dut.state), 0);
      check("burst_sent", int'(bus.sent_cnt_o), 5);

      // Clear while in HIGH with two pending; overflow still set from burst.
      bus.evt_valid_i = 1'b1;
      k = cyc + 1;
      exp_rise.push_back(k + 1);
      repeat (3) tick();
      check("clr_pre_pending", int'(bus.pending_o), 2);
      check("clr_pre_pulse", int'(bus.pulse_o), 1);
      check("clr_pre_overflow", int'(bus.overflow_o), 1);
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i       = 1'b0;
      bus.evt_valid_i = 1'b0;
      check("clr_pending", int'(bus.pending_o), 0);
      check("clr_overflow", int'(bus.overflow_o), 0);
      check("clr_pulse_kept", int'(bus.pulse_o), 1);
      repeat (20) tick();
      check("clr_sent", int'(bus.sent_cnt_o), 6);
      check("clr_no_more_pulses", exp_rise.size(), 0);
      check("clr_idle", int'(dut.state), 0);

      // Async reset in the second HIGH cycle.
      bus.evt_valid_i = 1'b1;
      k = cyc + 1;
      exp_rise.push_back(k + 1);
      tick();
      bus.evt_valid_i = 1'b0;
      repeat (2) tick();
      check("arst_pulse_before", int'(bus.pulse_o), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_same_cycle", cyc, k + 2);
      check_reset_outputs("arst");
      repeat (2) tick();
      check("arst_state", int'(dut.state), 0);
      rst_n = 1'b1;
      tick();

      // Sent counter wrap.
      force dut.sent_cnt = 16'hFFFF;
      tick();
      release dut.sent_cnt;
      check("wrap_preload", int'(bus.sent_cnt_o), 32'h0000FFFF);
      bus.evt_valid_i = 1'b1;
      k = cyc + 1;
      exp_rise.push_back(k + 1);
      tick();
      bus.evt_valid_i = 1'b0;
      repeat (5) tick();
      check("wrap_sent", int'(bus.sent_cnt_o), 0);
      repeat (4) tick();

      // End-to-end: random events versus downstream model count.
      sb_en     = 1'b0;
      acc       = 0;
      ds_base   = ds_cnt;
      sent_base = int'(bus.sent_cnt_o);
      for (int i = 0; i < 1000; i++) begin
         bus.evt_valid_i = 1'b1;
         if (bus.evt_ready_o) acc++;
         tick();
         bus.evt_valid_i = 1'b0;
         repeat ($urandom_range(0, 9)) tick();
      end
      for (int i = 0; i < 200; i++) begin
         if (dut.state == 2'd0 && bus.pending_o == '0) break;
         tick();
      end
      check("e2e_drained", int'(dut.state == 2'd0 && bus.pending_o == '0), 1);
      repeat (3) tick();
      check("e2e_count", int'(16'(bus.sent_cnt_o - 16'(sent_base))), ds_cnt - ds_base);
      check("e2e_accepted", int'(16'(bus.sent_cnt_o - 16'(sent_base))), acc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_evt_pulse_shaper
`default_nettype wire
